// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared FSM state type and default widths for the sequence detector
package seq_det_pkg;

  localparam int PAT_W_DEF = 8;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// rtl/seq_detect_ctrl_if.sv - serial bit stream handshake between source and detector
interface seq_detect_ctrl_if;

  logic in_valid;
  logic in_bit;
  logic in_ready;

  modport master (output in_valid, output in_bit, input in_ready);
  modport slave  (input in_valid, input in_bit, output in_ready);

endinterface

// File: rtl/seq_match_core.sv
// rtl/seq_match_core.sv - history shift register, fill counter and masked pattern compare
module seq_match_core
  import seq_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int LEN_W = $clog2(PAT_W) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             in_bit,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic             overlap,
  output logic             hit
);

  logic [PAT_W-1:0] hist;
  logic [PAT_W-1:0] hist_nx;
  logic [PAT_W-1:0] mask;
  logic [LEN_W-1:0] fill;
  logic [LEN_W-1:0] fill_nx;

  // hit is evaluated on the post-shift view so the top can register it on the accepting edge
  always_comb begin
    hist_nx = {hist[PAT_W-2:0], in_bit};
    fill_nx = (fill >= len) ? len : fill + 1'b1;
    mask    = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len));
    end
    hit = shift_en && (fill_nx == len) && ((hist_nx & mask) == (pattern & mask));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
      fill <= '0;
    end else if (clear) begin
      hist <= '0;
      fill <= '0;
    end else if (shift_en) begin
      hist <= hist_nx;
      fill <= (hit && !overlap) ? '0 : fill_nx;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// rtl/seq_detect_ctrl.sv - run-control FSM and match counter around the serial pattern matcher
module seq_detect_ctrl
  import seq_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PAT_W-1:0]       cfg_pattern,
  input  logic [$clog2(PAT_W):0] cfg_len,
  input  logic                   cfg_overlap,
  input  logic [CNT_W-1:0]       cfg_target,
  input  logic                   start,
  input  logic                   abort,
  seq_detect_ctrl_if.slave       stream,
  output logic                   match,
  output logic [CNT_W-1:0]       match_cnt,
  output logic                   busy,
  output logic                   done,
  output logic                   cfg_err
);

  localparam int LEN_W = $clog2(PAT_W) + 1;

  state_t           state;
  state_t           state_d;
  logic [PAT_W-1:0] sh_pattern;
  logic [LEN_W-1:0] sh_len;
  logic             sh_overlap;
  logic [CNT_W-1:0] sh_target;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_sat;
  logic             match_d;
  logic             cfg_err_d;
  logic             load;
  logic             shift_en;
  logic             hit;
  logic             len_ok;

  assign len_ok  = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));
  assign cnt_sat = (&match_cnt) ? match_cnt : match_cnt + 1'b1;

  seq_match_core #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (load),
    .shift_en (shift_en),
    .in_bit   (stream.in_bit),
    .pattern  (sh_pattern),
    .len      (sh_len),
    .overlap  (sh_overlap),
    .hit      (hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // abort wins over everything, so a bit offered on the abort cycle never reaches the core
  always_comb begin
    state_d   = state;
    cnt_d     = match_cnt;
    match_d   = 1'b0;
    cfg_err_d = 1'b0;
    load      = 1'b0;
    shift_en  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (start) begin
          if (len_ok) begin
            load    = 1'b1;
            cnt_d   = '0;
            state_d = ST_RUN;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (stream.in_valid && stream.in_ready) begin
          shift_en = 1'b1;
          if (hit) begin
            match_d = 1'b1;
            cnt_d   = cnt_sat;
            if ((sh_target != '0) && (cnt_sat == sh_target)) begin
              state_d = ST_DONE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_pattern      <= '0;
      sh_len          <= '0;
      sh_overlap      <= 1'b0;
      sh_target       <= '0;
      match_cnt       <= '0;
      match           <= 1'b0;
      cfg_err         <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      stream.in_ready <= 1'b0;
    end else begin
      if (load) begin
        sh_pattern <= cfg_pattern;
        sh_len     <= cfg_len;
        sh_overlap <= cfg_overlap;
        sh_target  <= cfg_target;
      end
      match_cnt       <= cnt_d;
      match           <= match_d;
      cfg_err         <= cfg_err_d;
      busy            <= (state_d == ST_RUN);
      done            <= (state_d == ST_DONE);
      stream.in_ready <= (state_d == ST_RUN);
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb/tb_seq_detect_ctrl.sv - directed self-checking bench for seq_detect_ctrl
module tb_seq_detect_ctrl;

  localparam int PAT_W = 8;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [PAT_W-1:0] cfg_pattern;
  logic [3:0]       cfg_len;
  logic             cfg_overlap;
  logic [CNT_W-1:0] cfg_target;
  logic             start;
  logic             abort;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic             busy;
  logic             done;
  logic             cfg_err;

  int n_cmp = 0;
  int n_err = 0;

  seq_detect_ctrl_if sif ();

  seq_detect_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_target  (cfg_target),
    .start       (start),
    .abort       (abort),
    .stream      (sif.slave),
    .match       (match),
    .match_cnt   (match_cnt),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic drive_bit(input logic v, input logic b);
    sif.in_valid = v;
    sif.in_bit   = b;
    @(negedge clk);
  endtask

  task automatic do_start(input logic [7:0] pat, input logic [3:0] len, input logic ov, input logic [7:0] tgt);
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ov;
    cfg_target  = tgt;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (match !== 1'b0) begin n_err++; $display("FAIL reset_match: got %b want 0", match); end
    n_cmp++; if (match_cnt !== 8'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", match_cnt); end
    n_cmp++; if ({sif.in_ready, busy, done, cfg_err} !== 4'b0000) begin n_err++; $display("FAIL reset_flags: got %b want 0000", {sif.in_ready, busy, done, cfg_err}); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if ({sif.in_ready, busy, done} !== 3'b000) begin n_err++; $display("FAIL post_reset_idle: got %b want 000", {sif.in_ready, busy, done}); end
  endtask

  task automatic test_overlap();
    logic sb [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic em [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    do_start(8'h0A, 4'd4, 1'b1, 8'd0);
    n_cmp++; if ({busy, sif.in_ready, done} !== 3'b110) begin n_err++; $display("FAIL ovl_armed: got %b want 110", {busy, sif.in_ready, done}); end
    for (int i = 0; i < 6; i++) begin
      drive_bit(1'b1, sb[i]);
      n_cmp++; if (match !== em[i]) begin n_err++; $display("FAIL ovl_match_bit%0d: got %b want %b", i + 1, match, em[i]); end
    end
    drive_bit(1'b0, 1'b0);
    n_cmp++; if (match !== 1'b0) begin n_err++; $display("FAIL ovl_idle_match: got %b want 0", match); end
    n_cmp++; if (match_cnt !== 8'd2) begin n_err++; $display("FAIL ovl_cnt: got %0d want 2", match_cnt); end
    do_abort();
    n_cmp++; if ({busy, match_cnt} !== {1'b0, 8'd2}) begin n_err++; $display("FAIL ovl_abort: got busy=%b cnt=%0d want busy=0 cnt=2", busy, match_cnt); end
  endtask

  task automatic test_non_overlap();
    logic sb [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic em [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    do_start(8'h0A, 4'd4, 1'b0, 8'd0);
    n_cmp++; if (match_cnt !== 8'd0) begin n_err++; $display("FAIL novl_cnt_clear: got %0d want 0", match_cnt); end
    for (int i = 0; i < 6; i++) begin
      drive_bit(1'b1, sb[i]);
      n_cmp++; if (match !== em[i]) begin n_err++; $display("FAIL novl_match_bit%0d: got %b want %b", i + 1, match, em[i]); end
    end
    sif.in_valid = 1'b0;
    n_cmp++; if (match_cnt !== 8'd1) begin n_err++; $display("FAIL novl_cnt: got %0d want 1", match_cnt); end
    do_abort();
  endtask

  task automatic test_target();
    logic sb [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic em [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    do_start(8'h0A, 4'd4, 1'b1, 8'd2);
    for (int i = 0; i < 6; i++) begin
      drive_bit(1'b1, sb[i]);
      n_cmp++; if (match !== em[i]) begin n_err++; $display("FAIL tgt_match_bit%0d: got %b want %b", i + 1, match, em[i]); end
    end
    n_cmp++; if ({done, busy, sif.in_ready} !== 3'b100) begin n_err++; $display("FAIL tgt_done: got %b want 100", {done, busy, sif.in_ready}); end
    drive_bit(1'b1, 1'b1);
    sif.in_valid = 1'b0;
    n_cmp++; if (match !== 1'b0) begin n_err++; $display("FAIL tgt_bit7_match: got %b want 0", match); end
    n_cmp++; if (match_cnt !== 8'd2) begin n_err++; $display("FAIL tgt_cnt: got %0d want 2", match_cnt); end
    n_cmp++; if ({done, sif.in_ready} !== 2'b10) begin n_err++; $display("FAIL tgt_hold: got %b want 10", {done, sif.in_ready}); end
    do_abort();
    n_cmp++; if ({done, busy, match_cnt} !== {2'b00, 8'd2}) begin n_err++; $display("FAIL tgt_abort: got done=%b busy=%b cnt=%0d want 0 0 2", done, busy, match_cnt); end
  endtask

  task automatic test_cfg_err();
    logic [3:0] bad [2] = '{4'd0, 4'd9};
    for (int i = 0; i < 2; i++) begin
      do_start(8'h0A, bad[i], 1'b1, 8'd0);
      n_cmp++; if (cfg_err !== 1'b1) begin n_err++; $display("FAIL cfgerr_pulse_len%0d: got %b want 1", bad[i], cfg_err); end
      n_cmp++; if ({busy, match_cnt} !== {1'b0, 8'd2}) begin n_err++; $display("FAIL cfgerr_idle_len%0d: got busy=%b cnt=%0d want 0 2", bad[i], busy, match_cnt); end
      @(negedge clk);
      n_cmp++; if (cfg_err !== 1'b0) begin n_err++; $display("FAIL cfgerr_one_cycle_len%0d: got %b want 0", bad[i], cfg_err); end
    end
  endtask

  task automatic test_abort();
    logic sb [3] = '{1'b1, 1'b0, 1'b1};
    do_start(8'h0A, 4'd4, 1'b0, 8'd0);
    for (int i = 0; i < 3; i++) begin
      drive_bit(1'b1, sb[i]);
      n_cmp++; if (match !== 1'b0) begin n_err++; $display("FAIL abt_match_bit%0d: got %b want 0", i + 1, match); end
    end
    abort = 1'b1;
    drive_bit(1'b1, 1'b0);
    abort = 1'b0;
    sif.in_valid = 1'b0;
    n_cmp++; if (match !== 1'b0) begin n_err++; $display("FAIL abt_no_match: got %b want 0", match); end
    n_cmp++; if ({busy, sif.in_ready, match_cnt} !== {2'b00, 8'd0}) begin n_err++; $display("FAIL abt_idle: got busy=%b rdy=%b cnt=%0d want 0 0 0", busy, sif.in_ready, match_cnt); end
    @(negedge clk);
    n_cmp++; if (match !== 1'b0) begin n_err++; $display("FAIL abt_late_match: got %b want 0", match); end
  endtask

  task automatic test_gaps_and_coincident();
    logic gv [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic gb [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic em [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_start(8'h0A, 4'd4, 1'b1, 8'd0);
    cfg_pattern = 8'hFF;
    cfg_len     = 4'd2;
    for (int i = 0; i < 9; i++) begin
      drive_bit(gv[i], gv[i] ? gb[i] : 1'($urandom_range(0, 1)));
      n_cmp++; if (match !== em[i]) begin n_err++; $display("FAIL gap_match_cyc%0d: got %b want %b", i + 1, match, em[i]); end
    end
    sif.in_valid = 1'b0;
    n_cmp++; if (match_cnt !== 8'd1) begin n_err++; $display("FAIL gap_cnt: got %0d want 1", match_cnt); end
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    n_cmp++; if ({busy, sif.in_ready, match_cnt} !== {2'b00, 8'd1}) begin n_err++; $display("FAIL coinc_run: got busy=%b rdy=%b cnt=%0d want 0 0 1", busy, sif.in_ready, match_cnt); end
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    n_cmp++; if ({busy, cfg_err} !== 2'b00) begin n_err++; $display("FAIL coinc_idle: got %b want 00", {busy, cfg_err}); end
  endtask

  task automatic test_saturation();
    do_start(8'h01, 4'd1, 1'b1, 8'd0);
    for (int i = 0; i < 260; i++) begin
      drive_bit(1'b1, 1'b1);
    end
    n_cmp++; if (match_cnt !== 8'd255) begin n_err++; $display("FAIL sat_cnt: got %0d want 255", match_cnt); end
    n_cmp++; if ({match, busy} !== 2'b11) begin n_err++; $display("FAIL sat_match: got %b want 11", {match, busy}); end
  endtask

  task automatic test_reset_midrun();
    sif.in_valid = 1'b1;
    sif.in_bit   = 1'b1;
    rst_n        = 1'b0;
    @(negedge clk);
    n_cmp++; if ({match, busy, sif.in_ready, match_cnt} !== {3'b000, 8'd0}) begin n_err++; $display("FAIL rstrun_hold: got m=%b b=%b r=%b cnt=%0d want 0 0 0 0", match, busy, sif.in_ready, match_cnt); end
    rst_n        = 1'b1;
    sif.in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if ({match, busy, done} !== 3'b000) begin n_err++; $display("FAIL rstrun_release: got %b want 000", {match, busy, done}); end
  endtask

  initial begin
    rst_n        = 1'b0;
    cfg_pattern  = '0;
    cfg_len      = '0;
    cfg_overlap  = 1'b0;
    cfg_target   = '0;
    start        = 1'b0;
    abort        = 1'b0;
    sif.in_valid = 1'b0;
    sif.in_bit   = 1'b0;
    test_reset();
    test_overlap();
    test_non_overlap();
    test_target();
    test_cfg_err();
    test_abort();
    test_gaps_and_coincident();
    test_saturation();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_detect_ctrl.md
SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

Interface
REQ-001 SHALL have parameter: PAT_W, 8, maximum pattern length in bits.
REQ-002 SHALL have parameter: CNT_W, 8, match counter width.
REQ-003 SHALL have port: clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: cfg_pattern  input  PAT_W  pattern; bit0 = most recent bit.
REQ-006 SHALL have port: cfg_len  input  $clog2(PAT_W)+1  pattern length; legal range 1..PAT_W.
REQ-007 SHALL have port: cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-008 SHALL have port: cfg_target  input  CNT_W  match count at which the run completes; 0 = unlimited.
REQ-009 SHALL have port: start  input  1  single-cycle pulse that arms a run.
REQ-010 SHALL have port: abort  input  1  single-cycle pulse that terminates a run.
REQ-011 SHALL have port: in_valid  input  1  serial bit valid.
REQ-012 SHALL have port: in_bit  input  1  serial data bit.
REQ-013 SHALL have port: in_ready  output  1  bit accepted when in_valid and in_ready are both 1.
REQ-014 SHALL have port: match  output  1  one-cycle pulse per detected pattern.
REQ-015 SHALL have port: match_cnt  output  CNT_W  matches in current/last run.
REQ-016 SHALL have port: busy  output  1  high in RUN.
REQ-017 SHALL have port: done  output  1  high in DONE.
REQ-018 SHALL have port: cfg_err  output  1  one-cycle pulse on start rejected for illegal cfg_len.

Function
REQ-019 SHALL implement FSM states IDLE, RUN, DONE; all outputs registered.
REQ-020 SHALL, in IDLE, on start with legal cfg_len: latch cfg_* into shadow registers, clear history, fill count and match_cnt, and enter RUN next edge.
REQ-021 SHALL, on start with cfg_len = 0 or > PAT_W: remain in IDLE, leave match_cnt unchanged, pulse cfg_err for one cycle.
REQ-022 SHALL drive in_ready = 1 only in RUN; each accepted bit shifts into bit0 of history, and fill count increments, saturating at len.
REQ-023 SHALL declare a match when, after the accepted bit, fill = len and history[len-1:0] = pattern[len-1:0].
REQ-024 SHALL assert match and update match_cnt on the edge after the completing bit is accepted (latency 1 cycle); no match without an accepted bit.
REQ-025 SHALL, on match with overlap = 0, clear fill count so that the next match needs len fresh bits; with overlap = 1, history and fill are kept.
REQ-026 SHALL saturate match_cnt at 2^CNT_W-1.
REQ-027 SHALL, when target != 0 and a match makes match_cnt = target, enter DONE on the same edge as that match pulse.
REQ-028 SHALL, in DONE, hold done = 1, in_ready = 0, and match_cnt stable until start (restarts per REQ-020) or abort (to IDLE).
REQ-029 SHALL, on abort in any state, enter IDLE next edge; match_cnt is retained; no match pulse is generated for a bit accepted on the abort cycle.
REQ-030 SHALL give abort priority when start and abort coincide; start in RUN is ignored.
REQ-031 SHALL ignore cfg_* changes while in RUN or DONE (shadow copies only).
REQ-032 SHALL treat in_valid gaps as stalls; history and fill count hold.

Reset
REQ-033 SHALL, while rst_n = 0: state IDLE, history/fill/shadows 0, match_cnt 0; in_ready, match, busy, done, cfg_err all 0.
REQ-034 SHALL let reset mid-run discard the run with no match pulse on release.

Structure
REQ-035 SHALL place the state enum and default PAT_W/CNT_W constants in shared package seq_det_pkg.
REQ-036 SHALL instantiate sub-module seq_match_core (shift register, fill counter, masked compare, overlap clear); FSM and counter stay in the top.

Verification
REQ-037 SHALL cover: pattern 4'b1010, len 4, overlap 1, target 0, bits 1,0,1,0,1,0 -> match after bits 4 and 6, match_cnt = 2.
REQ-038 SHALL cover: same stream, overlap 0 -> one match after bit 4, match_cnt = 1.
REQ-039 SHALL cover: overlap 1, target 2, stream 1010101 -> done after second match, in_ready = 0, bit 7 not accepted, match_cnt = 2.
REQ-040 SHALL cover: abort after bit 3 of 1010 -> IDLE next cycle, no match, busy = 0, match_cnt = 0.
REQ-041 SHALL cover: start with cfg_len = 0 and with cfg_len = 9 -> cfg_err pulse each, state stays IDLE.
REQ-042 SHALL cover: 1010 with random in_valid gaps plus start+abort coincident -> match timing per accepted bits; coincident pulse yields IDLE.
